// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA modular-exponentiation datapath:
// default widths, start-request polarity and controller state encodings.
package rsa_pkg;

    localparam int   DEF_DATA_WIDTH = 8;
    localparam logic DEF_START      = 1'b1;

    typedef enum logic [3:0] {
        IDLE,
        RED_ISSUE,
        RED_WAIT,
        SQR_ISSUE,
        SQR_WAIT,
        MUL_ISSUE,
        MUL_WAIT,
        FINISH,
        FAIL
    } modexp_state_t;

    // Bit-index register width; at least one bit even for a 1-bit operand.
    function automatic int idx_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/rsa_core_modexp.sv
// Left-to-right square-and-multiply modular exponentiation; every reduction
// is delegated to an external rsa_core_mod unit over the m_* handshake.
module rsa_core_modexp
    import rsa_pkg::*;
#(
    parameter int   DATA_WIDTH = DEF_DATA_WIDTH,
    parameter logic START      = DEF_START
) (
    input  logic                      exp_clk,
    input  logic                      exp_rst,
    input  logic                      exp_start,
    input  logic [DATA_WIDTH-1:0]     exp_base,
    input  logic [DATA_WIDTH-1:0]     exp_exp,
    input  logic [DATA_WIDTH-1:0]     exp_n,
    output logic                      exp_busy,
    output logic                      exp_done,
    output logic                      exp_err,
    output logic [DATA_WIDTH-1:0]     exp_c,
    output logic                      m_start,
    output logic [2*DATA_WIDTH-1:0]   m_a,
    output logic [DATA_WIDTH-1:0]     m_b,
    input  logic                      m_done,
    input  logic                      m_err,
    input  logic [DATA_WIDTH-1:0]     m_c
);

    localparam int W  = DATA_WIDTH;
    localparam int IW = idx_width(DATA_WIDTH);

    modexp_state_t   r_state;
    modexp_state_t   w_state_next;

    logic [W-1:0]    r_base;
    logic [W-1:0]    r_exp;
    logic [W-1:0]    r_n;
    logic [W-1:0]    r_bm;
    logic [W-1:0]    r_r;
    logic [IW-1:0]   r_i;
    logic            r_m_start;
    logic [2*W-1:0]  r_m_a;
    logic [W-1:0]    r_m_b;
    logic [W-1:0]    r_exp_c;

    logic            w_accept;
    logic            w_last_bit;
    logic            w_exp_bit;
    logic            w_red_ok;
    logic            w_red_bad;
    logic [2*W-1:0]  w_sqr;
    logic [2*W-1:0]  w_mul;

    assign w_accept   = (exp_start == START);
    assign w_last_bit = (r_i == '0);
    assign w_exp_bit  = r_exp[r_i];
    assign w_red_ok   = m_done && !m_err;
    assign w_red_bad  = m_done && m_err;

    // Full-width unsigned products feeding the reduction unit.
    assign w_sqr = {{W{1'b0}}, r_r} * {{W{1'b0}}, r_r};
    assign w_mul = {{W{1'b0}}, r_r} * {{W{1'b0}}, r_bm};

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_next = RED_ISSUE;
                end
            end
            RED_ISSUE: w_state_next = RED_WAIT;
            RED_WAIT: begin
                if (w_red_bad) begin
                    w_state_next = FAIL;
                end else if (w_red_ok) begin
                    w_state_next = SQR_ISSUE;
                end
            end
            SQR_ISSUE: w_state_next = SQR_WAIT;
            SQR_WAIT: begin
                if (w_red_bad) begin
                    w_state_next = FAIL;
                end else if (w_red_ok) begin
                    if (w_exp_bit) begin
                        w_state_next = MUL_ISSUE;
                    end else if (w_last_bit) begin
                        w_state_next = FINISH;
                    end else begin
                        w_state_next = SQR_ISSUE;
                    end
                end
            end
            MUL_ISSUE: w_state_next = MUL_WAIT;
            MUL_WAIT: begin
                if (w_red_bad) begin
                    w_state_next = FAIL;
                end else if (w_red_ok) begin
                    w_state_next = w_last_bit ? FINISH : SQR_ISSUE;
                end
            end
            FINISH:  w_state_next = IDLE;
            FAIL:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge exp_clk) begin
        if (exp_rst) begin
            r_state   <= IDLE;
            r_base    <= '0;
            r_exp     <= '0;
            r_n       <= '0;
            r_bm      <= '0;
            r_r       <= W'(1);
            r_i       <= '0;
            r_m_start <= 1'b0;
            r_m_a     <= '0;
            r_m_b     <= '0;
            r_exp_c   <= '0;
        end else begin
            r_state   <= w_state_next;
            r_m_start <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_base <= exp_base;
                        r_exp  <= exp_exp;
                        r_n    <= exp_n;
                        r_r    <= W'(1);
                        r_i    <= IW'(W - 1);
                    end
                end
                // Operands are registered here, so m_start rises in the first
                // WAIT cycle and m_a/m_b stay put until the reply arrives.
                RED_ISSUE: begin
                    r_m_start <= 1'b1;
                    r_m_a     <= {{W{1'b0}}, r_base};
                    r_m_b     <= r_n;
                end
                RED_WAIT: begin
                    if (w_red_ok) begin
                        r_bm <= m_c;
                    end
                end
                SQR_ISSUE: begin
                    r_m_start <= 1'b1;
                    r_m_a     <= w_sqr;
                    r_m_b     <= r_n;
                end
                SQR_WAIT: begin
                    if (w_red_ok) begin
                        r_r <= m_c;
                        if (!w_exp_bit && !w_last_bit) begin
                            r_i <= r_i - IW'(1);
                        end
                    end
                end
                MUL_ISSUE: begin
                    r_m_start <= 1'b1;
                    r_m_a     <= w_mul;
                    r_m_b     <= r_n;
                end
                MUL_WAIT: begin
                    if (w_red_ok && !w_last_bit) begin
                        r_r <= m_c;
                        r_i <= r_i - IW'(1);
                    end else if (w_red_ok) begin
                        r_r <= m_c;
                    end
                end
                default: begin
                end
            endcase

            // Result is loaded on the way into FINISH/FAIL so it is valid
            // in the same cycle as exp_done.
            if (w_state_next == FINISH) begin
                r_exp_c <= m_c;
            end else if (w_state_next == FAIL) begin
                r_exp_c <= '1;
            end
        end
    end

    assign exp_busy = (r_state != IDLE);
    assign exp_done = (r_state == FINISH) || (r_state == FAIL);
    assign exp_err  = (r_state == FAIL);
    assign exp_c    = r_exp_c;
    assign m_start  = r_m_start;
    assign m_a      = r_m_a;
    assign m_b      = r_m_b;

endmodule

// File: tb/tb_rsa_core_modexp.sv
// Scoreboard bench for rsa_core_modexp with a behavioural reduction unit
// answering each m_start after a random latency.
module tb_rsa_core_modexp;
    import rsa_pkg::*;

    localparam int   W   = 8;
    localparam logic STA = DEF_START;

    logic           exp_clk = 1'b0;
    logic           exp_rst;
    logic           exp_start;
    logic [W-1:0]   exp_base;
    logic [W-1:0]   exp_exp;
    logic [W-1:0]   exp_n;
    logic           exp_busy;
    logic           exp_done;
    logic           exp_err;
    logic [W-1:0]   exp_c;
    logic           m_start;
    logic [2*W-1:0] m_a;
    logic [W-1:0]   m_b;
    logic           m_done = 1'b0;
    logic           m_err  = 1'b0;
    logic [W-1:0]   m_c    = '0;

    rsa_core_modexp #(.DATA_WIDTH(W), .START(STA)) dut (
        .exp_clk   (exp_clk),
        .exp_rst   (exp_rst),
        .exp_start (exp_start),
        .exp_base  (exp_base),
        .exp_exp   (exp_exp),
        .exp_n     (exp_n),
        .exp_busy  (exp_busy),
        .exp_done  (exp_done),
        .exp_err   (exp_err),
        .exp_c     (exp_c),
        .m_start   (m_start),
        .m_a       (m_a),
        .m_b       (m_b),
        .m_done    (m_done),
        .m_err     (m_err),
        .m_c       (m_c)
    );

    always #5 exp_clk = ~exp_clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    typedef struct {
        string        tag;
        logic [W-1:0] c;
        logic         err;
        int           pulses;
        int           base_cnt;
    } exp_t;

    exp_t sb[$];

    int             start_cnt = 0;
    int             done_cnt  = 0;
    logic           prev_done = 1'b0;
    bit             red_busy  = 1'b0;
    int             red_wait  = 0;
    logic [2*W-1:0] red_a;
    logic [W-1:0]   red_b;

    // Monitor + reduction-unit model, all on the falling edge.
    always @(negedge exp_clk) begin
        exp_t e;
        m_done = 1'b0;
        m_err  = 1'b0;
        if (exp_rst) begin
            red_busy  = 1'b0;
            prev_done = 1'b0;
        end else begin
            if (exp_done) begin
                done_cnt++;
                check_eq("done_one_cycle", prev_done, 1'b0);
                check_eq("sb_depth", 64'(sb.size()), 64'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check_eq({e.tag, "_c"}, exp_c, e.c);
                    check_eq({e.tag, "_err"}, exp_err, e.err);
                    check_eq({e.tag, "_pulses"}, 64'(start_cnt - e.base_cnt), 64'(e.pulses));
                    $display("op %s: c=0x%0h err=%0b pulses=%0d", e.tag, exp_c, exp_err,
                             start_cnt - e.base_cnt);
                end
            end
            prev_done = exp_done;
            if (red_busy) begin
                check_eq("m_hold", {m_a, m_b}, {red_a, red_b});
                red_wait--;
                if (red_wait == 0) begin
                    m_done   = 1'b1;
                    m_err    = (red_b == '0);
                    m_c      = (red_b == '0) ? '0 : W'(red_a % {{W{1'b0}}, red_b});
                    red_busy = 1'b0;
                end
            end
            if (m_start) begin
                start_cnt++;
                red_a    = m_a;
                red_b    = m_b;
                red_wait = $urandom_range(1, 3);
                red_busy = 1'b1;
            end
        end
    end

    function automatic logic [W-1:0] ref_modexp(input logic [W-1:0] b, input logic [W-1:0] e,
                                                 input logic [W-1:0] n);
        longint r;
        longint bm;
        r  = 1;
        bm = longint'(b) % longint'(n);
        for (int k = W - 1; k >= 0; k--) begin
            r = (r * r) % longint'(n);
            if (e[k]) r = (r * bm) % longint'(n);
        end
        return W'(r);
    endfunction

    function automatic int pulses_for(input logic [W-1:0] e, input logic [W-1:0] n);
        return (n == '0) ? 1 : 1 + W + $countones(e);
    endfunction

    task automatic wait_idle();
        int g = 0;
        while (exp_busy && g < 500) begin
            @(negedge exp_clk); #1;
            g++;
        end
        if (exp_busy) check_eq("idle_timeout", exp_busy, 1'b0);
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] b, input logic [W-1:0] e,
                          input logic [W-1:0] n, input logic [W-1:0] want_c, input logic want_err);
        exp_t x;
        wait_idle();
        exp_base  = b;
        exp_exp   = e;
        exp_n     = n;
        exp_start = STA;
        x.tag      = tag;
        x.c        = want_c;
        x.err      = want_err;
        x.pulses   = pulses_for(e, n);
        x.base_cnt = start_cnt;
        sb.push_back(x);
        @(negedge exp_clk); #1;
        exp_start = ~STA;
        check_eq({tag, "_busy"}, exp_busy, 1'b1);
    endtask

    task automatic wait_done(input int prev);
        int g = 0;
        while (done_cnt == prev && g < 2000) begin
            @(negedge exp_clk); #1;
            g++;
        end
        if (done_cnt == prev) check_eq("done_timeout", 64'(done_cnt), 64'(prev + 1));
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_busy"},    exp_busy, 1'b0);
        check_eq({tag, "_done"},    exp_done, 1'b0);
        check_eq({tag, "_err"},     exp_err,  1'b0);
        check_eq({tag, "_c"},       exp_c,    '0);
        check_eq({tag, "_m_start"}, m_start,  1'b0);
        check_eq({tag, "_m_a"},     m_a,      '0);
        check_eq({tag, "_m_b"},     m_b,      '0);
    endtask

    initial begin
        logic [W-1:0] rb, re, rn;
        int           d0, g;

        exp_rst   = 1'b1;
        exp_start = ~STA;
        exp_base  = '0;
        exp_exp   = '0;
        exp_n     = '0;
        repeat (3) @(posedge exp_clk);
        #1;
        check_reset_outputs("rst");
        @(negedge exp_clk); #1;
        exp_rst = 1'b0;

        // Directed vectors, issued back to back.
        run_op("3^5%7",   8'd3,   8'd5,  8'd7,   8'd5,   1'b0);
        run_op("2^10%255", 8'd2,  8'd10, 8'd255, 8'd4,   1'b0);
        run_op("200^1%7", 8'd200, 8'd1,  8'd7,   8'd4,   1'b0);
        run_op("x^0%13",  8'd9,   8'd0,  8'd13,  8'd1,   1'b0);
        run_op("x^0%1",   8'd9,   8'd0,  8'd1,   8'd0,   1'b0);
        run_op("n0",      8'd5,   8'd3,  8'd0,   8'hFF,  1'b1);
        run_op("1^255%251", 8'd1, 8'd255, 8'd251, 8'd1,  1'b0);

        for (int k = 0; k < 6; k++) begin
            rb = W'($urandom);
            re = W'($urandom);
            rn = W'($urandom_range(1, 255));
            run_op($sformatf("rand%0d", k), rb, re, rn, ref_modexp(rb, re, rn), 1'b0);
        end
        wait_idle();

        // Start re-asserted with other operands while busy must be ignored.
        d0 = done_cnt;
        run_op("ignore", 8'd3, 8'd5, 8'd7, 8'd5, 1'b0);
        exp_base  = 8'd9;
        exp_exp   = 8'd9;
        exp_n     = 8'd11;
        exp_start = STA;
        repeat (5) begin
            @(negedge exp_clk); #1;
        end
        exp_start = ~STA;
        wait_done(d0);
        repeat (30) begin
            @(negedge exp_clk); #1;
        end
        check_eq("ignore_done_cnt", 64'(done_cnt - d0), 64'd1);
        check_eq("c_hold", exp_c, 8'd5);

        // Reset while the first squaring is outstanding.
        run_op("aborted", 8'd3, 8'd5, 8'd7, 8'd5, 1'b0);
        g = 0;
        while ((start_cnt - sb[0].base_cnt) < 2 && g < 200) begin
            @(negedge exp_clk); #1;
            g++;
        end
        check_eq("sqr_wait_reached", 64'(start_cnt - sb[0].base_cnt), 64'd2);
        exp_rst = 1'b1;
        sb.delete();
        @(posedge exp_clk); #1;
        check_reset_outputs("midrst");
        @(negedge exp_clk); #1;
        exp_rst = 1'b0;

        d0 = done_cnt;
        run_op("after_rst", 8'd3, 8'd5, 8'd7, 8'd5, 1'b0);
        wait_done(d0);
        wait_idle();
        check_eq("sb_empty", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
